// File: rtl/hexagon_render_axil_pkg.sv
// Shared constants for the hexagon_render AXI4-Lite register file:
// word offsets, STATUS/CTRL bit positions, response codes and the W-slot layout.
package hexagon_render_axil_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_CFG_FIRST = 3'd2;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int CTRL_START_BIT  = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } wslot_t;

  // Merge new_v into old_v one byte lane at a time under the write strobes.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hexagon_render_axil_regs_slot.sv
// One-entry holding slot: captures in_data when in_valid arrives while empty,
// stays full until release_i frees it. Ready to the sender is simply !full.
module hexagon_render_axil_regs_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         release_i,
  output logic         full,
  output logic [W-1:0] data
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (release_i) full_d = 1'b0;
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/hexagon_render_axil_regs.sv
// AXI4-Lite register file for the hexagon_render core: CTRL start pulse,
// STATUS busy/done-sticky and NUM_CFG byte-writable configuration words.
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// VALID and READY are both high; VALID, once raised, holds its payload stable
// until that edge, and READY never depends on VALID of the same channel.
module hexagon_render_axil_regs
  import hexagon_render_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_CFG            = 6
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [3:0]                      S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  input  logic                            core_busy,
  input  logic                            core_done,
  output logic [NUM_CFG*32-1:0]           cfg_out
);

  logic [2:0]  aw_word;
  logic        aw_full;
  wslot_t      w_slot;
  logic        w_full;
  logic        commit;

  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start_q, start_d;
  logic        done_sticky_q, done_sticky_d;
  logic [31:0] cfg_q [NUM_CFG];
  logic [31:0] cfg_d [NUM_CFG];
  logic        status_clear;
  logic [31:0] read_mux;
  logic [2:0]  read_word;

  // A commit only happens once the previous B response has been taken.
  assign commit = aw_full && w_full && !bvalid_q;

  hexagon_render_axil_regs_slot #(.W(3)) u_aw_slot (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .in_valid  (S_AXI_AWVALID),
    .in_data   (S_AXI_AWADDR[4:2]),
    .release_i (commit),
    .full      (aw_full),
    .data      (aw_word)
  );

  hexagon_render_axil_regs_slot #(.W($bits(wslot_t))) u_w_slot (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .in_valid  (S_AXI_WVALID),
    .in_data   ({S_AXI_WSTRB, S_AXI_WDATA[31:0]}),
    .release_i (commit),
    .full      (w_full),
    .data      (w_slot)
  );

  assign read_word = S_AXI_ARADDR[4:2];

  always_comb begin
    read_mux = 32'h0;
    if (read_word == REG_STATUS) begin
      read_mux[STATUS_BUSY_BIT] = core_busy;
      read_mux[STATUS_DONE_BIT] = done_sticky_q;
    end
    for (int i = 0; i < NUM_CFG; i++) begin
      if (read_word == 3'(i + int'(REG_CFG_FIRST))) read_mux = cfg_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CFG; i++) cfg_d[i] = cfg_q[i];
    start_d      = 1'b0;
    status_clear = 1'b0;
    if (commit) begin
      if (aw_word == REG_CTRL) begin
        start_d = w_slot.strb[0] && w_slot.data[CTRL_START_BIT];
      end else if (aw_word == REG_STATUS) begin
        status_clear = w_slot.strb[0] && w_slot.data[STATUS_DONE_BIT];
      end
      for (int i = 0; i < NUM_CFG; i++) begin
        if (aw_word == 3'(i + int'(REG_CFG_FIRST)))
          cfg_d[i] = apply_wstrb(cfg_q[i], w_slot.data, w_slot.strb);
      end
    end

    // A completion on the same edge as the W1C must not be lost.
    done_sticky_d = done_sticky_q;
    if (status_clear) done_sticky_d = 1'b0;
    if (core_done)    done_sticky_d = 1'b1;

    bvalid_d = bvalid_q;
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (commit)                   bvalid_d = 1'b1;

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (S_AXI_ARVALID && !rvalid_q) begin
      rvalid_d = 1'b1;
      rdata_d  = read_mux;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      bvalid_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= 32'h0;
      start_q       <= 1'b0;
      done_sticky_q <= 1'b0;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= 32'h0;
    end else begin
      bvalid_q      <= bvalid_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      start_q       <= start_d;
      done_sticky_q <= done_sticky_d;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= cfg_d[i];
    end
  end

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
    assign cfg_out[g*32 +: 32] = cfg_q[g];
  end

  // Readies are held low while reset is asserted so every output reads 0.
  assign S_AXI_AWREADY = !aw_full && S_AXI_ARESETN;
  assign S_AXI_WREADY  = !w_full && S_AXI_ARESETN;
  assign S_AXI_ARREADY = !rvalid_q && S_AXI_ARESETN;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign core_start    = start_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_hexagon_render_axil_regs.sv
// Bench for hexagon_render_axil_regs: directed scenarios plus random traffic,
// all checked every cycle against a queue/array model of the register file.
module tb_hexagon_render_axil_regs;

  localparam int NUM_CFG = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        core_start;
  logic        core_busy = 1'b0;
  logic        core_done = 1'b0;
  logic [NUM_CFG*32-1:0] cfg_out;

  hexagon_render_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .NUM_CFG(NUM_CFG)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
    .cfg_out(cfg_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0]  m_aw_q[$];
  logic [35:0] m_w_q[$];
  logic [31:0] m_cfg [NUM_CFG];
  logic        m_bvalid = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_sticky = 1'b0;
  logic        m_start = 1'b0;
  logic        m_aw_took = 1'b0;
  logic        m_w_took = 1'b0;
  logic        m_ar_took = 1'b0;

  initial for (int i = 0; i < NUM_CFG; i++) m_cfg[i] = '0;

  function automatic logic [31:0] model_read(input int word);
    if (word == 1) return {30'd0, m_sticky, core_busy};
    if (word >= 2) return m_cfg[word-2];
    return 32'd0;
  endfunction

  function automatic logic [NUM_CFG*32-1:0] model_flat();
    logic [NUM_CFG*32-1:0] v;
    for (int i = 0; i < NUM_CFG; i++) v[i*32 +: 32] = m_cfg[i];
    return v;
  endfunction

  always @(posedge clk) begin
    logic commit, b_hs, ar_hs, r_hs, aw_hs, w_hs, nsticky, nstart;
    logic [31:0] rd;
    int word;
    logic [3:0] st;
    logic [31:0] dt;
    m_aw_took = 1'b0;
    m_w_took  = 1'b0;
    m_ar_took = 1'b0;
    if (!rst_n) begin
      m_aw_q.delete();
      m_w_q.delete();
      m_bvalid = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_sticky = 1'b0;
      m_start  = 1'b0;
      for (int i = 0; i < NUM_CFG; i++) m_cfg[i] = '0;
    end else begin
      aw_hs  = awvalid && (m_aw_q.size() == 0);
      w_hs   = wvalid && (m_w_q.size() == 0);
      commit = (m_aw_q.size() != 0) && (m_w_q.size() != 0) && !m_bvalid;
      b_hs   = m_bvalid && bready;
      ar_hs  = arvalid && !m_rvalid;
      r_hs   = m_rvalid && rready;
      rd     = model_read(int'(araddr[4:2]));
      nstart = 1'b0;
      nsticky = m_sticky;
      if (commit) begin
        word = int'(m_aw_q[0][4:2]);
        {st, dt} = m_w_q[0];
        if (word == 0) nstart = st[0] && dt[0];
        else if (word == 1) begin
          if (st[0] && dt[1]) nsticky = 1'b0;
        end else begin
          for (int b = 0; b < 4; b++)
            if (st[b]) m_cfg[word-2][b*8 +: 8] = dt[b*8 +: 8];
        end
        void'(m_aw_q.pop_front());
        void'(m_w_q.pop_front());
      end
      if (core_done) nsticky = 1'b1;
      m_sticky = nsticky;
      m_start  = nstart;
      if (commit) m_bvalid = 1'b1;
      else if (b_hs) m_bvalid = 1'b0;
      if (ar_hs) begin
        m_rvalid = 1'b1;
        m_rdata  = rd;
      end else if (r_hs) m_rvalid = 1'b0;
      if (aw_hs) begin m_aw_q.push_back(awaddr); m_aw_took = 1'b1; end
      if (w_hs)  begin m_w_q.push_back({wstrb, wdata}); m_w_took = 1'b1; end
      m_ar_took = ar_hs;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("awready", awready, rst_n && (m_aw_q.size() == 0));
    chk("wready", wready, rst_n && (m_w_q.size() == 0));
    chk("arready", arready, rst_n && !m_rvalid);
    chk("bvalid", bvalid, m_bvalid);
    chk("bresp", bresp, 2'b00);
    chk("rvalid", rvalid, m_rvalid);
    chk("rresp", rresp, 2'b00);
    if (m_rvalid) chk("rdata", rdata, m_rdata);
    chk("core_start", core_start, m_start);
    chk("cfg_out", cfg_out, model_flat());
    if (core_start) start_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_aw(input logic [4:0] a);
    int n = 0;
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = a;
    do begin @(posedge clk); #1; n++; end while (!m_aw_took && n < 50);
    awvalid = 1'b0;
    if (!m_aw_took) chk("aw_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    wvalid = 1'b1; wdata = d; wstrb = s;
    do begin @(posedge clk); #1; n++; end while (!m_w_took && n < 50);
    wvalid = 1'b0;
    if (!m_w_took) chk("w_timeout", 1'b0, 1'b1);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic wait_bvalid();
    int n = 0;
    while (!m_bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!m_bvalid) chk("b_timeout", 1'b0, 1'b1);
  endtask

  task automatic take_b();
    wait_bvalid();
    chk("bresp_lit", bresp, 2'b00);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = a;
    do begin @(posedge clk); #1; n++; end while (!m_ar_took && n < 50);
    arvalid = 1'b0;
    if (!m_ar_took) chk("ar_timeout", 1'b0, 1'b1);
    d = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_cfg", cfg_out, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic write/read to CFG word 2.
    axi_write(5'h08, 32'hABCD0001, 4'hF);
    take_b();
    do_read(5'h08, rd);
    chk("cfg2_read", rd, 32'hABCD0001);
    chk("cfg2_out", cfg_out[31:0], 32'hABCD0001);

    // W ahead of AW, partial strobes over all-ones.
    axi_write(5'h1C, 32'hFFFFFFFF, 4'hF);
    take_b();
    fork
      send_w(32'hDEAD0011, 4'b0101);
      begin repeat (3) @(posedge clk); send_aw(5'h1C); end
    join
    take_b();
    do_read(5'h1C, rd);
    chk("cfg7_strb", rd, 32'hFFADFF11);

    // B back-pressure: second write is held in the slots.
    axi_write(5'h0C, 32'h11112222, 4'hF);
    wait_bvalid();
    axi_write(5'h10, 32'h33334444, 4'hF);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bhold_bvalid", bvalid, 1'b1);
      chk("bhold_cfg4", cfg_out[95:64], 32'h0);
    end
    take_b();
    take_b();
    do_read(5'h10, rd);
    chk("cfg4_after", rd, 32'h33334444);
    do_read(5'h0C, rd);
    chk("cfg3_after", rd, 32'h11112222);

    // CTRL start pulse and STATUS done/W1C.
    start_cnt = 0;
    axi_write(5'h00, 32'h1, 4'hF);
    take_b();
    repeat (3) @(posedge clk);
    #1;
    chk("start_once", start_cnt, 1);
    pulse_done();
    do_read(5'h04, rd);
    chk("status_done", rd, 32'h2);
    axi_write(5'h04, 32'h2, 4'hF);
    take_b();
    do_read(5'h04, rd);
    chk("status_w1c", rd, 32'h0);

    // W1C colliding with core_done: set wins.
    pulse_done();
    axi_write(5'h04, 32'h2, 4'hF);
    pulse_done();
    take_b();
    do_read(5'h04, rd);
    chk("status_race", rd, 32'h2);

    // Reset while AW is held in its slot with W still pending.
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = 5'h14;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    awvalid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_bvalid", bvalid, 1'b0);
    chk("rst_mid_cfg", cfg_out, '0);
    for (int w = 2; w < 8; w++) begin
      do_read(5'(w * 4), rd);
      chk("rst_cfg_read", rd, 32'h0);
    end

    // Random traffic, all channels and core inputs at once.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (awvalid && m_aw_took) awvalid = 1'b0;
      if (!awvalid && $urandom_range(0, 2) == 0) begin
        awvalid = 1'b1; awaddr = 5'($urandom_range(0, 31));
      end
      if (wvalid && m_w_took) wvalid = 1'b0;
      if (!wvalid && $urandom_range(0, 2) == 0) begin
        wvalid = 1'b1; wdata = $urandom(); wstrb = 4'($urandom_range(0, 15));
      end
      if (arvalid && m_ar_took) arvalid = 1'b0;
      if (!arvalid && $urandom_range(0, 2) == 0) begin
        arvalid = 1'b1; araddr = 5'($urandom_range(0, 31));
      end
      bready    = 1'($urandom_range(0, 1));
      rready    = 1'($urandom_range(0, 1));
      core_done = ($urandom_range(0, 5) == 0);
      core_busy = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1; core_done = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_bvalid", bvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
